arbitro_rr16: RTL and testbench



---
 rtl/arbitro_rr16.sv | 119 +++++++++++
 tb/tb_arbitro_rr16.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/arbitro_rr16.sv
// 16-way round-robin arbiter: highest-index priority encoder with a rotating mask.
// Optional hold timeout under `ARB_TIMEOUT_EN`.
module arbitro_rr16 #(
  parameter int N        = 16,
  parameter int IDX_W    = 4,
  parameter int MAX_HOLD = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req,
  input  logic             done,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_valid,
  output logic             timeout
);

  if (N != (1 << IDX_W) || MAX_HOLD < 1) begin : g_cfg_bad
    $error("arbitro_rr16: N must equal 2**IDX_W and MAX_HOLD must be >= 1");
  end

  typedef enum logic {S_IDLE, S_GRANT} state_t;

  state_t           r_state, w_state_nxt;
  logic [IDX_W-1:0] r_ptr, w_ptr_nxt;
  logic [N-1:0]     w_mask, w_masked, w_cand, w_grant_nxt;
  logic [IDX_W-1:0] w_win, w_idx_nxt;
  logic             w_vld_nxt, w_release, w_force;

  // Mask keeps only requesters strictly below the last granted index.
  for (genvar gi = 0; gi < N; gi++) begin : g_lane
    assign w_mask[gi] = (IDX_W'(gi) < r_ptr);
  end

  assign w_masked  = req & w_mask;
  assign w_cand    = (|w_masked) ? w_masked : req;
  assign w_release = done | ~req[grant_idx];

  always_comb begin
    w_win = '0;
    for (int i = 0; i < N; i++)
      if (w_cand[i]) w_win = IDX_W'(i);
  end

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(MAX_HOLD + 1);
  logic [CNT_W-1:0] r_hold;
  logic             r_timeout;

  // Forced release fires on the edge where the counter would reach MAX_HOLD.
  assign w_force = (r_state == S_GRANT) && !w_release &&
                   (r_hold == CNT_W'(MAX_HOLD - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold    <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= w_force;
      if (r_state == S_IDLE) r_hold <= '0;
      else                   r_hold <= r_hold + 1'b1;
    end
  end

  assign timeout = r_timeout;
`else
  assign w_force = 1'b0;
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_ptr       <= '0;
      grant       <= '0;
      grant_idx   <= '0;
      grant_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_ptr       <= w_ptr_nxt;
      grant       <= w_grant_nxt;
      grant_idx   <= w_idx_nxt;
      grant_valid <= w_vld_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (|req)                w_state_nxt = S_GRANT;
      S_GRANT: if (w_release | w_force) w_state_nxt = S_IDLE;
      default:                          w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_grant_nxt = grant;
    w_idx_nxt   = grant_idx;
    w_vld_nxt   = grant_valid;
    w_ptr_nxt   = r_ptr;
    case (r_state)
      S_IDLE: if (|req) begin
        w_grant_nxt = N'(1) << w_win;
        w_idx_nxt   = w_win;
        w_vld_nxt   = 1'b1;
      end
      S_GRANT: if (w_release | w_force) begin
        w_grant_nxt = '0;
        w_vld_nxt   = 1'b0;
        w_ptr_nxt   = grant_idx;
      end
      default: begin
        w_grant_nxt = '0;
        w_vld_nxt   = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_arbitro_rr16.sv
// Self-checking bench for arbitro_rr16: rotating-search reference model checked
// every cycle, directed sequences with literal expectations, then random traffic.
module tb_arbitro_rr16;
  localparam int N = 16, IDX_W = 4, MAX_HOLD = 15;
`ifdef ARB_TIMEOUT_EN
  localparam bit TMO = 1'b1;
`else
  localparam bit TMO = 1'b0;
`endif

  logic             clk   = 1'b0;
  logic             rst_n = 1'b1;
  logic [N-1:0]     req   = '0;
  logic             done  = 1'b0;
  logic [N-1:0]     grant;
  logic [IDX_W-1:0] grant_idx;
  logic             grant_valid;
  logic             timeout;

  arbitro_rr16 #(.N(N), .IDX_W(IDX_W), .MAX_HOLD(MAX_HOLD)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .done(done),
    .grant(grant), .grant_idx(grant_idx), .grant_valid(grant_valid), .timeout(timeout)
  );

  always #5 clk = ~clk;

  int n_checks = 0, n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: search downward from ptr-1, wrapping, so the last winner comes last.
  function automatic int pick(input logic [N-1:0] r, input int p);
    for (int k = 1; k <= N; k++) begin
      int c;
      c = (p - k + N) % N;
      if (r[c]) return c;
    end
    return 0;
  endfunction

  bit m_busy = 0, m_to = 0;
  int m_holder = 0, m_ptr = 0, m_hold = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 0; m_to <= 0; m_holder <= 0; m_ptr <= 0; m_hold <= 0;
    end else begin
      m_to <= 0;
      if (!m_busy) begin
        if (req != 0) begin
          m_holder <= pick(req, m_ptr);
          m_busy   <= 1;
          m_hold   <= 0;
        end
      end else if (done || !req[m_holder]) begin
        m_busy <= 0;
        m_ptr  <= m_holder;
      end else if (TMO && (m_hold + 1 == MAX_HOLD)) begin
        m_busy <= 0;
        m_ptr  <= m_holder;
        m_to   <= 1;
      end else begin
        m_hold <= m_hold + 1;
      end
    end
  end

  always @(negedge clk) begin
    check("grant_valid", grant_valid, m_busy);
    check("grant", grant, m_busy ? (32'd1 << m_holder) : 32'd0);
    check("grant_idx", grant_idx, m_holder);
    check("timeout", timeout, m_to);
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  int seq_q[$];

  task automatic reset_pulse();
    @(negedge clk); #1 rst_n = 1'b0;
    @(negedge clk); #1 rst_n = 1'b1;
  endtask

  task automatic collect(input logic [N-1:0] r, input int n);
    reset_pulse();
    req = r; done = 1'b1;
    seq_q.delete();
    for (int c = 0; c < n * 4 && seq_q.size() < n; c++) begin
      @(negedge clk);
      if (grant_valid) seq_q.push_back(int'(grant_idx));
    end
    check("seq_len", seq_q.size(), n);
  endtask

  initial begin
    int e1[4];
    int e2[5];
    int hi;
    bit held;
    int dp;
    e1 = '{15, 0, 15, 0};
    e2 = '{11, 7, 3, 11, 7};

    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_grant", grant, 0);
    check("rst_idx", grant_idx, 0);
    check("rst_valid", grant_valid, 0);
    check("rst_timeout", timeout, 0);
    #1 rst_n = 1'b1;
    repeat (10) begin
      @(negedge clk);
      check("idle_valid", grant_valid, 0);
    end

    req = 16'h2000;
    @(negedge clk);
    check("g13_grant", grant, 16'h2000);
    check("g13_idx", grant_idx, 13);
    req = 16'hA000;
    repeat (3) @(negedge clk);
    check("g13_hold", grant, 16'h2000);
    done = 1'b1;
    @(negedge clk);
    check("g13_release", grant_valid, 0);
    done = 1'b0;
    @(negedge clk);
    check("wrap_idx", grant_idx, 15);
    req = '0; done = 1'b1;
    @(negedge clk);
    done = 1'b0;

    collect(16'h8001, 4);
    for (int i = 0; i < 4; i++) check("rr_8001", seq_q[i], e1[i]);

    collect(16'h0888, 5);
    for (int i = 0; i < 5; i++) check("rr_0888", seq_q[i], e2[i]);
    done = 1'b0; req = 16'h0808;
    @(negedge clk);
    check("withdraw_release", grant_valid, 0);
    @(negedge clk);
    check("withdraw_next_idx", grant_idx, 3);
    check("withdraw_next_vld", grant_valid, 1);
    req = '0; done = 1'b1;
    @(negedge clk);
    done = 1'b0;

    reset_pulse();
    req = 16'h0100;
    @(negedge clk);
    check("pre_rst_idx", grant_idx, 8);
    done = 1'b1;
    @(negedge clk);
    done = 1'b0; req = 16'h0180;
    @(negedge clk);
    check("masked_idx", grant_idx, 7);
    #2 rst_n = 1'b0;
    #1;
    check("async_grant", grant, 0);
    check("async_valid", grant_valid, 0);
    check("async_idx", grant_idx, 0);
    check("async_timeout", timeout, 0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_fixed", grant_idx, 8);
    req = '0; done = 1'b1;
    @(negedge clk);
    done = 1'b0;

    reset_pulse();
    req = 16'h0010; done = 1'b0;
`ifdef ARB_TIMEOUT_EN
    hi = 0;
    @(negedge clk);
    while (grant_valid && hi < 40) begin
      hi++;
      @(negedge clk);
    end
    check("hold_cycles", hi, MAX_HOLD);
    check("timeout_pulse", timeout, 1);
    @(negedge clk);
    check("timeout_clear", timeout, 0);
    check("regrant_vld", grant_valid, 1);
    check("regrant_idx", grant_idx, 4);
`else
    held = 1'b1;
    @(negedge clk);
    repeat (110) begin
      if (!grant_valid || timeout) held = 1'b0;
      @(negedge clk);
    end
    check("held_110", held, 1);
`endif
    req = '0; done = 1'b1;
    @(negedge clk);
    done = 1'b0;

    reset_pulse();
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      dp = ((c / 500) % 2 == 1) ? 40 : 4;
      if ($urandom_range(0, dp - 1) == 0)
        req = N'($urandom) & N'($urandom);
      done = ($urandom_range(0, dp) == 0);
      if ($urandom_range(0, 499) == 0) begin
        #1 rst_n = 1'b0;
        #1 rst_n = 1'b1;
      end
    end
    req = '0; done = 1'b0;
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
